tt_sweep_ctrl: RTL

- Sequencer that exhaustively characterises a generated combinational function bank (N_IN inputs, N_OUT outputs, e.g. the 2-in/16-out all-functions circuits).
- Drives every input vector in ascending order, waits a settle time, and captures each output into a per-output truth table.
- Optionally compares the captured tables against a golden table.
- Sits between the dataset test harness (start/done) and one combinational DUT instance.

---
 rtl/tt_sweep_pkg.sv | 24 ++
 rtl/tt_settle_timer.sv | 28 ++
 rtl/tt_sweep_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared state codes and sizing helpers for the truth-table sweep controller.
package tt_sweep_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_APPLY  = 2'd1;
  localparam state_t S_SAMPLE = 2'd2;
  localparam state_t S_DONE   = 2'd3;

  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int tt_idx(input int k, input int v, input int n_in);
    return k * n_vec(n_in) + v;
  endfunction

  // Counter width able to hold SETTLE_CYC-1; never narrower than one bit.
  function automatic int settle_w(input int settle_cyc);
    return (settle_cyc > 1) ? $clog2(settle_cyc) : 1;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam int CW = settle_w(SETTLE_CYC);
  localparam logic [CW-1:0] LOAD_V = (SETTLE_CYC > 0) ? CW'(SETTLE_CYC - 1) : '0;

  logic [CW-1:0] r_cnt;

  // Loading SETTLE_CYC-1 makes the hold state last exactly SETTLE_CYC cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst)                      r_cnt <= '0;
    else if (i_load)                r_cnt <= LOAD_V;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - CW'(1);
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweeper for a combinational function bank.
// Optional golden compare is built when TT_SWEEP_GOLDEN_CHECK_EN is defined.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int N_OUT      = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [N_IN-1:0]               o_x,
  input  logic [N_OUT-1:0]              i_f,
  output logic [N_OUT*(2**N_IN)-1:0]    o_tt,
  output logic                          o_tt_valid
`ifdef TT_SWEEP_GOLDEN_CHECK_EN
  ,
  input  logic [N_OUT*(2**N_IN)-1:0]    i_golden,
  output logic [N_OUT-1:0]              o_mismatch,
  output logic                          o_pass
`endif
);

  localparam int NV  = n_vec(N_IN);
  localparam int TTW = N_OUT * NV;
  // With no settle time the hold state is skipped and every cycle samples.
  localparam state_t S_HOLD = (SETTLE_CYC == 0) ? S_SAMPLE : S_APPLY;

  state_t          r_state;
  logic [N_IN:0]   r_x;
  logic [TTW-1:0]  r_tt;
  logic            r_tt_valid;

  logic            w_accept;
  logic            w_last;
  logic            w_expired;
  logic [NV-1:0]   w_dec;
  logic [TTW-1:0]  w_tt_nxt;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_x == (N_IN+1)'(NV - 1));
  assign w_dec    = (r_state == S_SAMPLE) ? (NV'(1) << r_x[N_IN-1:0]) : '0;

  tt_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_accept || ((r_state == S_SAMPLE) && !w_last)),
    .i_dec     (r_state == S_APPLY),
    .o_expired (w_expired)
  );

  // Table as it will be after this cycle's sample: column x of every row takes f.
  for (genvar k = 0; k < N_OUT; k++) begin : g_row
    assign w_tt_nxt[tt_idx(k, 0, N_IN) +: NV] =
      (r_tt[tt_idx(k, 0, N_IN) +: NV] & ~w_dec) | ({NV{i_f[k]}} & w_dec);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_tt       <= '0;
      r_tt_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state    <= S_HOLD;
          r_x        <= '0;
          r_tt       <= '0;
          r_tt_valid <= 1'b0;
        end
        S_APPLY: if (w_expired) r_state <= S_SAMPLE;
        S_SAMPLE: begin
          r_tt <= w_tt_nxt;
          if (w_last) begin
            r_state    <= S_DONE;
            r_x        <= '0;
            r_tt_valid <= 1'b1;
          end else begin
            r_state <= S_HOLD;
            r_x     <= r_x + (N_IN+1)'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == S_APPLY) || (r_state == S_SAMPLE);
  assign o_done     = (r_state == S_DONE);
  assign o_x        = r_x[N_IN-1:0];
  assign o_tt       = r_tt;
  assign o_tt_valid = r_tt_valid;

`ifdef TT_SWEEP_GOLDEN_CHECK_EN
  logic [N_OUT-1:0] w_mis;
  logic [N_OUT-1:0] r_mis;
  logic             r_pass;

  for (genvar k = 0; k < N_OUT; k++) begin : g_cmp
    assign w_mis[k] = (w_tt_nxt[tt_idx(k, 0, N_IN) +: NV] != i_golden[tt_idx(k, 0, N_IN) +: NV]);
  end

  // Compared against the post-sample table so the last vector is included.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept) begin
      r_mis  <= '0;
      r_pass <= 1'b0;
    end else if ((r_state == S_SAMPLE) && w_last) begin
      r_mis  <= w_mis;
      r_pass <= ~|w_mis;
    end
  end

  assign o_mismatch = r_mis;
  assign o_pass     = r_pass;
`endif

endmodule
